sm2_mod_reduce_seq: RTL and testbench
=====================================

// Module: sm2_mod_reduce_seq
// PURPOSE
//  Sequential, handshaked SM2 prime-field reducer: out = in_data mod p, p = FFFFFFFE FFFFFFFF ... 00000000 FFFFFFFFFFFFFFFF.
//  It accepts any 512-bit value, not only products of reduced operands. Reduction folds the part above bit 256 using
//  2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p), one fold per cycle, then applies one conditional subtraction of p.
//  Sits behind the 256x256 multiplier in the point-arithmetic datapath. A tag travels with each request.
// PARAMETERS
//  TAG_W     4    width of the request tag returned with the result
//  MAX_FOLD  16   fold-count limit; exceeding it flags out_err (must never happen for a correct fold)
//  X_W       514  internal accumulator width (>= 483 required; 514 gives margin)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid & in_ready
//  in_data    in   512    value to reduce
//  in_tag     in   TAG_W  request tag
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer ready
//  out_data   out  256    result, in [0, p-1] when out_err=0
//  out_tag    out  TAG_W  tag of the request
//  out_err    out  1      fold limit hit; qualified by out_valid
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset (rst high at clk edge): state=IDLE; out_valid=0, out_data=0, out_tag=0, out_err=0, fold_cnt=0, X=0.
//    in_ready is 0 while rst is high. Reset mid-operation abandons the request; no output is produced.
//  - FSM states IDLE -> FOLD -> SUB -> DONE -> IDLE. in_ready = (state==IDLE) & ~rst. One request in flight at a time.
//  - IDLE: on handshake, X <= zero-extended in_data, tag captured, fold_cnt <= 0, next state FOLD.
//  - FOLD: H = X[X_W-1:256], L = X[255:0].
//    H==0: next state SUB.
//    H!=0 and fold_cnt==MAX_FOLD: out_data <= L, out_err <= 1, next state DONE.
//    Otherwise: X <= L + (H<<224) + (H<<96) + H - (H<<64) at X_W bits, which is never negative; fold_cnt++.
//  - SUB: X < 2^256 < 2p. out_data <= (X >= p) ? X - p : X, out_err <= 0, next state DONE.
//  - DONE: out_valid=1 with out_data, out_tag and out_err stable. On out_ready, next state IDLE and out_valid drops.
//    A new request can be accepted no earlier than the cycle after the output handshake.
//  - Latency: with handshake at edge k and F folds, out_valid rises after edge k+F+2.
//    F=0 for in_data < 2^256. F <= 10 for any 512-bit input.
//  - Boundary cases: in_data=p gives 0; in_data=p-1 gives p-1; in_data=2^256-1 gives 2^224+2^96-2^64 (F=0, one subtraction).
//    Fold results that carry back to bit 256 take one further fold; this is covered by the H!=0 loop.
//  - out_ready held high in IDLE, FOLD or SUB has no effect.
//  - in_valid/in_data outside IDLE are ignored and not sampled.
// STRUCTURE
//  - sm2_pkg: SM2_P constant (256-bit), state localparams IDLE/FOLD/SUB/DONE, the reduction identity offsets 224/96/64.
//  - Sub-module sm2_fold_step (combinational): X_W-bit X in, X_W-bit folded value out, plus hi_zero flag.
//    The top level holds the FSM, registers, conditional subtraction and handshake logic.
// TESTING
//  Compare every result against a (in_data % SM2_P) model function in the bench.
//  1. Reset, then in_data=0, tag=3, out_ready=1 -> out_data=0, out_tag=3, out_err=0, out_valid exactly 2 cycles after handshake.
//  2. in_data=p, then p-1, then 2^256-1 -> 0, then p-1, then 2^224+2^96-2^64; all with F=0.
//  3. in_data = C2395071...34A0CED5 * B1BF7EC4...CB66E009 -> 35FE7919 6AAB8D8A F83F199B FE3B0B69 4A02B1CC 57048932 93838BD3 258A7593.
//  4. in_data=2^512-1, with out_ready low for 5 cycles in DONE -> result equals the model.
//     out_valid, out_data and out_tag are stable while stalled. in_ready stays 0 until the cycle after the output handshake.
//  5. rst pulsed in the 3rd FOLD cycle of a 2^512-1 request -> no out_valid appears.
//     The next request, in_data=5, returns 5 with fold_cnt restarted.
//  6. MAX_FOLD=2 build with in_data=2^512-1 -> out_err=1, out_valid=1 after the 3rd FOLD cycle.
//     Then run 1000 random 512-bit requests (MAX_FOLD=16) with random out_ready -> zero mismatches, out_err never set.

Source files
------------

// File: rtl/sm2_pkg.sv
// Shared constants for the SM2 prime-field reducer: the prime, FSM states and
// the shift offsets of the identity 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p).
package sm2_pkg;

  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  localparam int unsigned FOLD_SH_HI  = 224;
  localparam int unsigned FOLD_SH_MID = 96;
  localparam int unsigned FOLD_SH_LO  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } sm2_state_e;

endpackage

// File: rtl/sm2_fold_step.sv
// One combinational fold: moves everything above bit 256 back into the low
// part using 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p).
module sm2_fold_step
  import sm2_pkg::*;
#(
  parameter int unsigned X_W = 514
) (
  input  logic [X_W-1:0] x_i,
  output logic [X_W-1:0] x_fold_o,
  output logic           hi_zero_o
);

  localparam int unsigned H_W = X_W - 256;

  logic [H_W-1:0] h;
  logic [X_W-1:0] h_ext;
  logic [X_W-1:0] l_ext;

  assign h         = x_i[X_W-1:256];
  assign h_ext     = X_W'(h);
  assign l_ext     = X_W'(x_i[255:0]);
  assign hi_zero_o = (h == '0);

  // The +2^224 term dominates the -2^64 term, so the result never wraps.
  assign x_fold_o = l_ext + (h_ext << FOLD_SH_HI) + (h_ext << FOLD_SH_MID)
                  + h_ext - (h_ext << FOLD_SH_LO);

endmodule

// File: rtl/sm2_mod_reduce_seq.sv
// Sequential handshaked reducer: out_data = in_data mod p (SM2 prime), one fold
// per cycle followed by a single conditional subtraction of p.
module sm2_mod_reduce_seq
  import sm2_pkg::*;
#(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned MAX_FOLD = 16,
  parameter int unsigned X_W      = 514
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(MAX_FOLD + 1);

  sm2_state_e       state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [255:0]     data_q, data_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [X_W-1:0]   x_fold;
  logic             hi_zero;
  logic [255:0]     x_lo;
  logic [255:0]     x_sub;
  logic             x_ge_p;

  sm2_fold_step #(
    .X_W (X_W)
  ) u_fold (
    .x_i       (x_q),
    .x_fold_o  (x_fold),
    .hi_zero_o (hi_zero)
  );

  // In SUB the accumulator is below 2^256 < 2p, so one subtraction suffices.
  assign x_lo   = x_q[255:0];
  assign x_ge_p = (x_lo >= SM2_P);
  assign x_sub  = x_lo - SM2_P;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;
  assign busy      = busy_q;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = X_W'(in_data);
          tag_d   = in_tag;
          cnt_d   = '0;
          state_d = FOLD;
        end
      end
      FOLD: begin
        if (hi_zero) begin
          state_d = SUB;
        end else if (cnt_q == CNT_W'(MAX_FOLD)) begin
          data_d  = x_lo;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          x_d   = x_fold;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SUB: begin
        data_d  = x_ge_p ? x_sub : x_lo;
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_sm2_mod_reduce_seq.sv
// Randomised self-checking bench for sm2_mod_reduce_seq against a plain
// (in_data % p) reference, plus directed latency, stall, reset and error cases.
module tb_sm2_mod_reduce_seq;

  localparam logic [255:0] P_REF =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_data = '0;
  logic [3:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_data;
  logic [3:0]   out_tag;
  logic         out_err;
  logic         busy;

  logic         e_in_valid = 1'b0;
  logic         e_in_ready;
  logic [511:0] e_in_data = '0;
  logic [3:0]   e_in_tag = '0;
  logic         e_out_valid;
  logic         e_out_ready = 1'b0;
  logic [255:0] e_out_data;
  logic [3:0]   e_out_tag;
  logic         e_out_err;
  logic         e_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm2_mod_reduce_seq #(.TAG_W(4), .MAX_FOLD(16), .X_W(514)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  sm2_mod_reduce_seq #(.TAG_W(4), .MAX_FOLD(2), .X_W(514)) dut_err (
    .clk(clk), .rst(rst),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data), .in_tag(e_in_tag),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data),
    .out_tag(e_out_tag), .out_err(e_out_err), .busy(e_busy)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_mod(input logic [511:0] v);
    logic [511:0] p512;
    p512 = {256'd0, P_REF};
    return 256'(v % p512);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    case ($urandom % 4)
      0: r[511:256] = '0;
      1: r[511:480] = '1;
      default: ;
    endcase
    return r;
  endfunction

  // One request through the main DUT; exp_lat < 0 skips the latency check.
  task automatic run_req(input logic [511:0] d, input logic [3:0] t, input logic [255:0] exp,
                         input int stall, input bit rnd_ready, input int exp_lat);
    int  n;
    int  lat;
    int  s;
    bit  rdy;
    in_data  = d;
    in_tag   = t;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rand512();
    lat = 0;
    while (!out_valid && lat < 100) begin
      out_ready = rnd_ready ? 1'($urandom % 2) : (stall == 0);
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      check("result_timeout", 1'b0, 1'b1);
      return;
    end
    if (exp_lat >= 0) check("latency", 512'(lat), 512'(exp_lat));
    check("data", out_data, exp);
    check("tag", out_tag, t);
    check("err", out_err, 1'b0);
    check("busy_done", busy, 1'b1);
    s = 0;
    while (s < 200) begin
      rdy = rnd_ready ? 1'($urandom % 2) : (s >= stall);
      out_ready = rdy;
      @(posedge clk); #1;
      if (rdy) break;
      s++;
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, exp);
      check("stall_tag", out_tag, t);
      check("stall_in_ready", in_ready, 1'b0);
    end
    check("post_hs_valid", out_valid, 1'b0);
    check("post_hs_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] d;
    int  n;
    bit  seen;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 256'd0);
    check("rst_tag", out_tag, 4'd0);
    check("rst_err", out_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);

    // Zero input, fixed two-cycle latency
    run_req(512'd0, 4'd3, 256'd0, 0, 1'b0, 2);

    // Boundaries around p and 2^256
    run_req({256'd0, P_REF}, 4'd1, 256'd0, 0, 1'b0, 2);
    run_req({256'd0, P_REF - 256'd1}, 4'd2, P_REF - 256'd1, 0, 1'b0, 2);
    a = (256'd1 << 224) + (256'd1 << 96) - (256'd1 << 64);
    run_req({256'd0, {256{1'b1}}}, 4'd4, a, 0, 1'b0, 2);

    // Products of reduced operands, as seen behind the multiplier
    for (int i = 0; i < 4; i++) begin
      a = 256'($urandom) ;
      for (int j = 0; j < 8; j++) a[j*32 +: 32] = $urandom;
      for (int j = 0; j < 8; j++) b[j*32 +: 32] = $urandom;
      a = a % P_REF;
      b = b % P_REF;
      d = {256'd0, a} * {256'd0, b};
      run_req(d, 4'(i + 8), ref_mod(d), 0, 1'b0, -1);
    end

    // All-ones input with a five-cycle output stall
    d = '1;
    run_req(d, 4'd9, ref_mod(d), 5, 1'b0, -1);

    // Reset in the third FOLD cycle abandons the request
    out_ready = 1'b1;
    in_data   = '1;
    in_tag    = 4'd6;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_fold", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("in_ready_during_rst", in_ready, 1'b0);
    @(posedge clk); #1;
    check("busy_after_rst", busy, 1'b0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_valid_after_rst", seen, 1'b0);
    run_req(512'd5, 4'd5, 256'd5, 0, 1'b0, 2);

    // MAX_FOLD=2 build runs out of folds on the all-ones input
    e_in_data  = '1;
    e_in_tag   = 4'd7;
    e_in_valid = 1'b1;
    #1;
    check("e_in_ready", e_in_ready, 1'b1);
    @(posedge clk); #1;
    e_in_valid = 1'b0;
    n = 0;
    while (!e_out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("e_latency", 512'(n), 512'd3);
    check("e_err", e_out_err, 1'b1);
    check("e_tag", e_out_tag, 4'd7);
    e_out_ready = 1'b1;
    @(posedge clk); #1;
    e_out_ready = 1'b0;
    check("e_valid_drop", e_out_valid, 1'b0);

    // Random requests with random consumer back-pressure
    for (int i = 0; i < 1000; i++) begin
      d = rand512();
      run_req(d, 4'($urandom), ref_mod(d), 0, 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
